wb_write_arbiter: RTL and testbench

Writeback arbiter and scoreboard that drives the register file's single write port. It merges two result sources: the in-order pipeline writeback, which cannot stall, and a long-latency unit (mult/div, load-miss) that delivers results through a valid/ready handshake. It tracks which registers have outstanding long-latency writes and raises a decode-stage stall when a source operand is still pending. It sits between the WB stage / long-latency unit and the register file write inputs.

---
 rtl/wb_write_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Merges the non-stallable pipeline writeback with a queued long-latency
// result stream. A scoreboard tracks registers with writes still in flight
// and raises a decode-stage stall when a source operand is pending.
module wb_write_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PIPE_we,
  input  logic [4:0]        PIPE_addr,
  input  logic [DATA_W-1:0] PIPE_data,
  input  logic              LL_issue,
  input  logic [4:0]        LL_issue_addr,
  input  logic              LL_valid,
  output logic              LL_ready,
  input  logic [4:0]        LL_addr,
  input  logic [DATA_W-1:0] LL_data,
  input  logic [4:0]        RD_address1,
  input  logic [4:0]        RD_address2,
  output logic              STALL,
  output logic [31:0]       BUSY_vec,
  output logic              REG_write_1,
  output logic [4:0]        REG_address_wr,
  output logic [DATA_W-1:0] REG_data_wb_in1
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [4:0]        q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       busy;
  logic [31:0]       busy_next;

  logic              pipe_sel;
  logic              push;
  logic              pop;
  logic [4:0]        head_addr;
  logic [DATA_W-1:0] head_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Arbitration: pipeline wins unless it targets r0; queue pops when not blocked.
  // Ready comes from the registered count, so a same-cycle pop never frees a slot.
  always_comb begin
    pipe_sel  = PIPE_we && (PIPE_addr != 5'd0);
    LL_ready  = (count < FULL_CNT);
    push      = LL_valid && LL_ready;
    pop       = !pipe_sel && (count != '0);
    head_addr = q_addr[rd_ptr];
    head_data = q_data[rd_ptr];
  end

  // Result queue storage: write at tail on push.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else if (push) begin
      q_addr[wr_ptr] <= LL_addr;
      q_data[wr_ptr] <= LL_data;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scoreboard update: clear on pop first, then issue so a same-edge set wins.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head_addr] = 1'b0;
    if (LL_issue && (LL_issue_addr != 5'd0)) busy_next[LL_issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) busy <= '0;
    else        busy <= busy_next;
  end

  // Registered write port; address/data hold when no write is presented.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      REG_write_1     <= 1'b0;
      REG_address_wr  <= '0;
      REG_data_wb_in1 <= '0;
    end else if (pipe_sel) begin
      REG_write_1     <= 1'b1;
      REG_address_wr  <= PIPE_addr;
      REG_data_wb_in1 <= PIPE_data;
    end else if (pop && (head_addr != 5'd0)) begin
      REG_write_1     <= 1'b1;
      REG_address_wr  <= head_addr;
      REG_data_wb_in1 <= head_data;
    end else begin
      REG_write_1     <= 1'b0;
    end
  end

  // Decode-stage hazard detect and scoreboard visibility.
  always_comb begin
    STALL    = busy[RD_address1] | busy[RD_address2];
    BUSY_vec = busy;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed table-driven bench for wb_write_arbiter, plus a hand-written
// mid-stream reset sequence.
module tb_wb_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PIPE_we;
  logic [4:0]  PIPE_addr;
  logic [31:0] PIPE_data;
  logic        LL_issue;
  logic [4:0]  LL_issue_addr;
  logic        LL_valid;
  logic        LL_ready;
  logic [4:0]  LL_addr;
  logic [31:0] LL_data;
  logic [4:0]  RD_address1;
  logic [4:0]  RD_address2;
  logic        STALL;
  logic [31:0] BUSY_vec;
  logic        REG_write_1;
  logic [4:0]  REG_address_wr;
  logic [31:0] REG_data_wb_in1;

  wb_write_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .PIPE_we(PIPE_we), .PIPE_addr(PIPE_addr), .PIPE_data(PIPE_data),
    .LL_issue(LL_issue), .LL_issue_addr(LL_issue_addr),
    .LL_valid(LL_valid), .LL_ready(LL_ready), .LL_addr(LL_addr), .LL_data(LL_data),
    .RD_address1(RD_address1), .RD_address2(RD_address2),
    .STALL(STALL), .BUSY_vec(BUSY_vec),
    .REG_write_1(REG_write_1), .REG_address_wr(REG_address_wr),
    .REG_data_wb_in1(REG_data_wb_in1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        pwe;
    logic [4:0]  paddr;
    logic [31:0] pdata;
    logic        iss;
    logic [4:0]  iaddr;
    logic        llv;
    logic [4:0]  lladdr;
    logic [31:0] lldata;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_ready;
    logic [31:0] e_busy;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    PIPE_we = 0; PIPE_addr = 0; PIPE_data = 0;
    LL_issue = 0; LL_issue_addr = 0;
    LL_valid = 0; LL_addr = 0; LL_data = 0;
    RD_address1 = 0; RD_address2 = 0;
  endtask

  task automatic check_outputs(input int idx, input logic we, input logic [4:0] a,
                               input logic [31:0] d, input logic st,
                               input logic rdy, input logic [31:0] bz);
    check("REG_write_1", idx, {31'd0, REG_write_1}, {31'd0, we});
    check("REG_address_wr", idx, {27'd0, REG_address_wr}, {27'd0, a});
    check("REG_data_wb_in1", idx, REG_data_wb_in1, d);
    check("STALL", idx, {31'd0, STALL}, {31'd0, st});
    check("LL_ready", idx, {31'd0, LL_ready}, {31'd0, rdy});
    check("BUSY_vec", idx, BUSY_vec, bz);
  endtask

  initial begin
    // pwe paddr pdata | iss iaddr | llv lladdr lldata | rd1 rd2 || we addr data stall ready busy
    tbl[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0,          0, 0, 1, 3,  32'hDEADBEEF, 0, 1, 32'h0};
    tbl[1]  = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 0, 0, 3,  32'hDEADBEEF, 0, 1, 32'h0};
    tbl[2]  = '{1, 0, 32'h11111111, 0, 0, 0, 0, 0,          0, 0, 0, 3,  32'hDEADBEEF, 0, 1, 32'h0};
    tbl[3]  = '{0, 0, 0,            1, 7, 0, 0, 0,          7, 0, 0, 3,  32'hDEADBEEF, 1, 1, 32'h80};
    tbl[4]  = '{0, 0, 0,            0, 0, 0, 0, 0,          7, 0, 0, 3,  32'hDEADBEEF, 1, 1, 32'h80};
    tbl[5]  = '{0, 0, 0,            0, 0, 1, 7, 32'h12345678, 7, 0, 0, 3, 32'hDEADBEEF, 1, 1, 32'h80};
    tbl[6]  = '{0, 0, 0,            0, 0, 0, 0, 0,          7, 0, 1, 7,  32'h12345678, 0, 1, 32'h0};
    tbl[7]  = '{0, 0, 0,            0, 0, 0, 0, 0,          7, 0, 0, 7,  32'h12345678, 0, 1, 32'h0};
    // contention: pipeline every cycle, three results offered, only two fit
    tbl[8]  = '{1, 1, 32'hA1,       0, 0, 1, 10, 32'hC0,    0, 0, 1, 1,  32'hA1,       0, 1, 32'h0};
    tbl[9]  = '{1, 2, 32'hA2,       0, 0, 1, 11, 32'hC1,    0, 0, 1, 2,  32'hA2,       0, 0, 32'h0};
    tbl[10] = '{1, 3, 32'hA3,       0, 0, 1, 12, 32'hC2,    0, 0, 1, 3,  32'hA3,       0, 0, 32'h0};
    tbl[11] = '{1, 4, 32'hA4,       0, 0, 1, 12, 32'hC2,    0, 0, 1, 4,  32'hA4,       0, 0, 32'h0};
    tbl[12] = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 0, 1, 10, 32'hC0,       0, 1, 32'h0};
    tbl[13] = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 0, 1, 11, 32'hC1,       0, 1, 32'h0};
    tbl[14] = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 0, 0, 11, 32'hC1,       0, 1, 32'h0};
    // same-edge clear and set of r9
    tbl[15] = '{0, 0, 0,            1, 9, 0, 0, 0,          9, 0, 0, 11, 32'hC1,       1, 1, 32'h200};
    tbl[16] = '{0, 0, 0,            0, 0, 1, 9, 32'h99,     9, 0, 0, 11, 32'hC1,       1, 1, 32'h200};
    tbl[17] = '{0, 0, 0,            1, 9, 0, 0, 0,          9, 0, 1, 9,  32'h99,       1, 1, 32'h200};
    tbl[18] = '{0, 0, 0,            0, 0, 1, 9, 32'h9A,     0, 9, 0, 9,  32'h99,       1, 1, 32'h200};
    tbl[19] = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 9, 1, 9,  32'h9A,       0, 1, 32'h0};
    // r0 result is popped silently
    tbl[20] = '{0, 0, 0,            0, 0, 1, 0, 32'h55,     0, 0, 0, 9,  32'h9A,       0, 1, 32'h0};
    tbl[21] = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 0, 0, 9,  32'h9A,       0, 1, 32'h0};
    tbl[22] = '{0, 0, 0,            0, 0, 0, 0, 0,          0, 0, 0, 9,  32'h9A,       0, 1, 32'h0};
    // pipeline write to r0 does not block a pop
    tbl[23] = '{0, 0, 0,            0, 0, 1, 6, 32'h66,     0, 0, 0, 9,  32'h9A,       0, 1, 32'h0};
    tbl[24] = '{1, 0, 32'hFF,       0, 0, 0, 0, 0,          0, 0, 1, 6,  32'h66,       0, 1, 32'h0};

    drive_idle();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs(-1, 0, 0, 0, 0, 1, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      PIPE_we = tbl[i].pwe; PIPE_addr = tbl[i].paddr; PIPE_data = tbl[i].pdata;
      LL_issue = tbl[i].iss; LL_issue_addr = tbl[i].iaddr;
      LL_valid = tbl[i].llv; LL_addr = tbl[i].lladdr; LL_data = tbl[i].lldata;
      RD_address1 = tbl[i].rd1; RD_address2 = tbl[i].rd2;
      @(posedge CLK);
      #1;
      check_outputs(i, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_data,
                    tbl[i].e_stall, tbl[i].e_ready, tbl[i].e_busy);
    end

    // Mid-stream reset with two queued results and r5 busy.
    @(negedge CLK);
    drive_idle();
    PIPE_we = 1; PIPE_addr = 1; PIPE_data = 32'hB1; LL_issue = 1; LL_issue_addr = 5;
    @(negedge CLK);
    LL_issue = 0; PIPE_addr = 2; PIPE_data = 32'hB2;
    LL_valid = 1; LL_addr = 5; LL_data = 32'hD1;
    @(negedge CLK);
    PIPE_addr = 3; PIPE_data = 32'hB3; LL_addr = 8; LL_data = 32'hD2;
    @(posedge CLK);
    #1;
    check("pre_reset_ready", 100, {31'd0, LL_ready}, 32'd0);
    check("pre_reset_busy", 100, BUSY_vec, 32'h20);
    drive_idle();
    RD_address1 = 5;
    #2;
    RST_N = 1'b0;
    #1;
    check_outputs(101, 0, 0, 0, 0, 1, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      check("post_reset_we", 110 + k, {31'd0, REG_write_1}, 32'd0);
      check("post_reset_busy", 110 + k, BUSY_vec, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
